// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serial driver for a 16-bit SPI DAC with a single-entry pending sample buffer
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   sample       in   offset-binary sample from the waveform generator
//   sample_valid in   one-cycle strobe on the sample-rate tick
//   dac_cs_n     out  DAC chip select, active low
//   dac_sclk     out  serial clock, idles low, DAC samples on rising edge
//   dac_mosi     out  serial data, MSB first
//   dac_ldac_n   out  DAC load strobe, active low
//   busy         out  frame in progress
//   overrun      out  sticky: a pending sample was overwritten before it was sent
//
// Build option: define DAC_LDAC_EN to pulse dac_ldac_n low during DONE;
// otherwise dac_ldac_n is tied low and the DAC updates on dac_cs_n rising.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    output logic              dac_cs_n,
    output logic              dac_sclk,
    output logic              dac_mosi,
    output logic              dac_ldac_n,
    output logic              busy,
    output logic              overrun
);
    localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_e;

    state_e            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              phase_q, phase_d;
    logic [DATA_W-1:0] sr_q, sr_d, pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic              overrun_q, overrun_d;
    logic              cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d;
    logic              tick;

    assign tick = div_q == 8'(CLK_DIV - 1);

    always_comb begin
        state_d     = state_q;
        div_d       = (state_q == IDLE || tick) ? '0 : div_q + 8'd1;
        bit_d       = bit_q;
        phase_d     = phase_q;
        sr_d        = sr_q;
        pend_d      = sample_valid ? sample : pend_q;
        pend_full_d = pend_full_q;
        overrun_d   = overrun_q;
        case (state_q)
            IDLE: if (sample_valid || pend_full_q) begin
                state_d     = SETUP;
                sr_d        = pend_full_q ? pend_q : sample;
                pend_full_d = pend_full_q && sample_valid;
            end
            SETUP: if (tick) begin
                state_d = SHIFT;
                phase_d = 1'b0;
                bit_d   = '0;
            end
            SHIFT: if (tick) begin
                phase_d = !phase_q;
                // a bit ends after its high phase; the next bit is presented
                // on the same edge sclk falls
                if (phase_q) begin
                    sr_d  = sr_q << 1;
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_W - 1)) begin
                        state_d = HOLD;
                        bit_d   = '0;
                    end
                end
            end
            HOLD: if (tick) state_d = DONE;
            DONE: if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && sample_valid) begin
            pend_full_d = 1'b1;
            overrun_d   = overrun_q || pend_full_q;
        end
        // outputs are registered from the current state, so they trail the
        // state register by one cycle
        cs_n_d = !(state_q inside {SETUP, SHIFT, HOLD});
        sclk_d = state_q == SHIFT && phase_q;
        mosi_d = (state_q == SETUP || state_q == SHIFT) && sr_q[DATA_W-1];
        busy_d = state_q != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            phase_q     <= 1'b0;
            sr_q        <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            phase_q     <= phase_d;
            sr_q        <= sr_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            overrun_q   <= overrun_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
        end
    end

`ifdef DAC_LDAC_EN
    logic ldac_n_q;

    always_ff @(posedge clk) begin
        if (!rst_n) ldac_n_q <= 1'b1;
        else ldac_n_q <= state_q != DONE;
    end

    assign dac_ldac_n = ldac_n_q;
`else
    assign dac_ldac_n = 1'b0;
`endif

    assign dac_cs_n = cs_n_q;
    assign dac_sclk = sclk_q;
    assign dac_mosi = mosi_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed bench for dac_spi_tx decoding the serial stream back into words
module tb_dac_spi_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic        cs_n, sclk, mosi, ldac_n, busy, overrun;
    logic        cs1, sclk1, mosi1, ldac1, busy1, ovr1;

    always #5 clk = ~clk;

    dac_spi_tx #(.CLK_DIV(2), .DATA_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
        .dac_cs_n(cs_n), .dac_sclk(sclk), .dac_mosi(mosi), .dac_ldac_n(ldac_n),
        .busy(busy), .overrun(overrun)
    );

    dac_spi_tx #(.CLK_DIV(1), .DATA_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
        .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_mosi(mosi1), .dac_ldac_n(ldac1),
        .busy(busy1), .overrun(ovr1)
    );

    typedef struct {
        logic [15:0] word;
        int          nbits;
        int          low;
        int          gap;
    } frame_t;

    typedef struct {
        logic [15:0] smp;
        logic [15:0] exp_word;
        int          exp_bits;
        int          exp_low;
        int          exp_first;
        int          exp_last;
        int          exp_busy_fall;
    } vec_t;

    int tests = 0;
    int fails = 0;

    frame_t      fq[$];
    logic [15:0] word = '0;
    int          nbits = 0, lowcnt = 0, highcnt = 0, gap_last = 0, mosi_viol = 0;
    int          ldac_run = 0, ldac_len = 0, ldac_ones = 0;
    logic        p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_busy = 1'b0, p_ldac = 1'b1;
    time         t0 = 0, t_cs_fall = 0, t_cs_rise = 0, t_busy_rise = 0, t_busy_fall = 0;
    time         t_first = 0, t_last = 0, t_ldac_fall = 0;

    // serial decoder for the CLK_DIV=2 instance, sampled on the falling edge
    always @(negedge clk) begin
        if (!cs_n) begin
            if (p_cs) begin
                t_cs_fall = $time;
                lowcnt = 0;
                nbits = 0;
                word = '0;
                gap_last = highcnt;
            end
            lowcnt++;
            if (sclk && !p_sclk) begin
                word = {word[14:0], mosi};
                if (nbits == 0) t_first = $time;
                t_last = $time;
                nbits++;
            end
        end else begin
            if (!p_cs) begin
                fq.push_back('{word, nbits, lowcnt, gap_last});
                t_cs_rise = $time;
                highcnt = 0;
            end
            highcnt++;
        end
        if (p_sclk && sclk && mosi != p_mosi) mosi_viol++;
        if (busy && !p_busy) t_busy_rise = $time;
        if (!busy && p_busy) t_busy_fall = $time;
        if (!ldac_n) begin
            if (p_ldac) begin
                t_ldac_fall = $time;
                ldac_run = 0;
            end
            ldac_run++;
        end else begin
            if (!p_ldac) ldac_len = ldac_run;
            ldac_ones++;
        end
        p_cs = cs_n;
        p_sclk = sclk;
        p_mosi = mosi;
        p_busy = busy;
        p_ldac = ldac_n;
    end

    logic [15:0] w1 = '0, f1_word = '0;
    int          low1 = 0, n1 = 0, f1_low = 0, f1_n = 0;
    bit          got1 = 1'b0;
    logic        p_cs1 = 1'b1, p_sclk1 = 1'b0;

    // first frame of the CLK_DIV=1 instance
    always @(negedge clk) begin
        if (!cs1) begin
            if (p_cs1) begin
                low1 = 0;
                w1 = '0;
                n1 = 0;
            end
            low1++;
            if (sclk1 && !p_sclk1) begin
                w1 = {w1[14:0], mosi1};
                n1++;
            end
        end else if (!p_cs1 && !got1) begin
            got1 = 1'b1;
            f1_low = low1;
            f1_word = w1;
            f1_n = n1;
        end
        p_cs1 = cs1;
        p_sclk1 = sclk1;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // one-cycle strobe; t0 marks the falling edge just before the accepting edge
    task automatic strobe(input logic [15:0] v);
        @(negedge clk);
        #1;
        sample = v;
        sample_valid = 1'b1;
        t0 = $time - 1;
        @(negedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    // edge index k in "accept edge N + k" for an event seen on a falling edge
    function automatic int off(input time t);
        return int'((t - t0) / 10) - 1;
    endfunction

    task automatic get_frame(output frame_t f);
        int n = 0;
        while (fq.size() == 0 && n < 300) begin
            cyc(1);
            n++;
        end
        if (fq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL frame_timeout: no frame after %0d cycles, expected one", n);
            f = '{16'h0000, -1, -1, -1};
        end else begin
            f = fq.pop_front();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            cyc(1);
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", n);
        end
        cyc(3);
    endtask

    vec_t   vecs[4];
    frame_t f;

    initial begin
        vecs[0] = '{16'hA5C3, 16'b1010_0101_1100_0011, 16, 68, 5, 65, 71};
        vecs[1] = '{16'h0000, 16'h0000, 16, 68, 5, 65, 71};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16, 68, 5, 65, 71};
        vecs[3] = '{16'h8000, 16'h8000, 16, 68, 5, 65, 71};

        cyc(3);
        chk("rst_cs_n", int'(cs_n), 1);
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_mosi", int'(mosi), 0);
`ifdef DAC_LDAC_EN
        chk("rst_ldac_n", int'(ldac_n), 1);
`else
        chk("rst_ldac_n", int'(ldac_n), 0);
`endif
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_cs1", int'(cs1), 1);
        rst_n = 1'b1;
        cyc(3);

        for (int i = 0; i < 4; i++) begin
            strobe(vecs[i].smp);
            get_frame(f);
            chk($sformatf("v%0d_word", i), int'(f.word), int'(vecs[i].exp_word));
            chk($sformatf("v%0d_bits", i), f.nbits, vecs[i].exp_bits);
            chk($sformatf("v%0d_cs_low", i), f.low, vecs[i].exp_low);
            chk($sformatf("v%0d_cs_fall", i), off(t_cs_fall), 1);
            chk($sformatf("v%0d_busy_rise", i), off(t_busy_rise), 1);
            chk($sformatf("v%0d_first_rise", i), off(t_first), vecs[i].exp_first);
            chk($sformatf("v%0d_last_rise", i), off(t_last), vecs[i].exp_last);
            wait_idle();
            chk($sformatf("v%0d_busy_fall", i), off(t_busy_fall), vecs[i].exp_busy_fall);
`ifdef DAC_LDAC_EN
            chk($sformatf("v%0d_ldac_len", i), ldac_len, 2);
            chk($sformatf("v%0d_ldac_start", i), int'((t_ldac_fall - t_cs_rise) / 10), 0);
`endif
        end
        chk("div1_done", int'(got1), 1);
        chk("div1_cs_low", f1_low, 34);
        chk("div1_word", int'(f1_word), 16'hA5C3);
        chk("div1_bits", f1_n, 16);

        // second sample arriving mid-frame is queued and sent next;
        // the gap is the DONE phase plus the single IDLE cycle
        strobe(16'hBEEF);
        cyc(20);
        strobe(16'h1234);
        chk("pend_overrun_mid", int'(overrun), 0);
        get_frame(f);
        chk("pend_first_word", int'(f.word), 16'hBEEF);
        get_frame(f);
        chk("pend_second_word", int'(f.word), 16'h1234);
        chk("pend_second_bits", f.nbits, 16);
        chk("pend_cs_gap", f.gap, 3);
        wait_idle();
        chk("pend_overrun_end", int'(overrun), 0);

        // three strobes in one frame: the middle one is lost
        strobe(16'h1111);
        cyc(10);
        strobe(16'h2222);
        cyc(5);
        strobe(16'h3333);
        chk("ovr_set", int'(overrun), 1);
        get_frame(f);
        chk("ovr_first_word", int'(f.word), 16'h1111);
        get_frame(f);
        chk("ovr_second_word", int'(f.word), 16'h3333);
        wait_idle();
        cyc(50);
        chk("ovr_no_extra_frame", fq.size(), 0);
        chk("ovr_sticky", int'(overrun), 1);

        // reset in the middle of bit 7
        strobe(16'h5A5A);
        begin
            int n = 0;
            while (!(cs_n == 1'b0 && nbits >= 7) && n < 200) begin
                cyc(1);
                n++;
            end
            chk("rst_mid_reached_bit7", int'(nbits >= 7), 1);
        end
        rst_n = 1'b0;
        cyc(1);
        chk("rst_mid_cs_n", int'(cs_n), 1);
        chk("rst_mid_sclk", int'(sclk), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        get_frame(f);
        chk("rst_mid_partial_bits", f.nbits, 7);
        cyc(5);
        chk("rst_mid_no_pending", fq.size(), 0);
        strobe(16'hC0DE);
        get_frame(f);
        chk("rst_after_word", int'(f.word), 16'hC0DE);
        chk("rst_after_bits", f.nbits, 16);
        chk("rst_after_cs_low", f.low, 68);
        wait_idle();

        chk("mosi_stable_sclk_high", mosi_viol, 0);
`ifndef DAC_LDAC_EN
        chk("ldac_const0", ldac_ones, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
